spi_slave_piso: RTL and testbench
=================================

Name: spi_slave_piso

Overview:
- Parallel-in/serial-out transmit path of the SPI slave; the MISO-side counterpart of the SIPO receive shifter.
- Accepts one DATA_W-bit word from the slave control logic through a valid/ready handshake.
- Holds the word until the master asserts SS_n, then shifts it out MSB-first on MISO, one bit per clk.
- Pulses tx_done when the last bit has been presented.

Parameters:
DATA_W, 8, width of the transmitted word (minimum 2)
CNT_W, $clog2(DATA_W+2), width of the internal bit counter

Ports:
clk  input  1  single system clock; all logic on posedge
rst  input  1  synchronous, active-high reset
SS_n  input  1  slave select, active low; low enables shifting
tx_valid  input  1  tx_data is valid this cycle
tx_data  input  DATA_W  word to transmit
tx_ready  output  1  block can accept a word
MISO  output  1  serial data to master
busy  output  1  high in LOADED and SHIFT states
tx_done  output  1  one-cycle pulse after a completed word

Behaviour:
- Reset: rst sampled at posedge.
  - Reset values: MISO=0, tx_ready=1, busy=0, tx_done=0.
  - Internal reset values: shreg=0, cnt=0, state=IDLE.
  - Reset mid-transfer aborts immediately and does not pulse tx_done.
- FSM states: IDLE, LOADED, SHIFT.
- IDLE:
  - tx_ready=1.
  - tx_valid&&tx_ready at posedge: shreg<=tx_data, tx_ready<=0, busy<=1, state->LOADED.
  - tx_valid=0: no change.
- LOADED:
  - Word held indefinitely while SS_n=1; tx_valid ignored.
  - First posedge with SS_n=0: MISO<=shreg[DATA_W-1], shreg<=shreg<<1, cnt<=1, state->SHIFT.
- SHIFT, SS_n=0, cnt<DATA_W: MISO<=shreg[DATA_W-1], shreg shifts left, cnt<=cnt+1.
- SHIFT, SS_n=0, cnt==DATA_W: the last bit has been visible one full cycle. At this posedge:
  - tx_done<=1 for exactly one cycle, MISO<=0, cnt<=0.
  - busy<=0, tx_ready<=1, state->IDLE.
- Latency: bit i (0=MSB) is on MISO during cycle i+1 after the start posedge. tx_done is high during cycle DATA_W+1.
- SS_n=1 during SHIFT (master abort):
  - At that posedge: state->IDLE, MISO<=0, cnt<=0, tx_ready<=1, busy<=0.
  - No tx_done; the remaining bits are discarded.
- Back-to-back: tx_ready is high in the tx_done cycle, so a word offered then is accepted and a new LOADED phase starts next cycle.
- tx_data is sampled only at the accept edge; later changes have no effect.
- MISO is a registered output with no combinational path from SS_n. Tri-stating is done outside this block.

Optional Feature:
- Macro: SPI_TX_PARITY_EN.
- Defined:
  - At accept, an odd-parity bit (~^tx_data) is captured.
  - After the DATA_W data bits, this parity bit is driven on MISO for one extra cycle. Completion is at cnt==DATA_W+1, so tx_done is delayed by one cycle.
  - Abort rules are unchanged; abort during the parity cycle gives no tx_done.
- Undefined: exactly DATA_W bits, as described above. No parity logic is synthesized.

Decomposition:
- Package spi_tx_pkg holds:
  - the state typedef: enum logic [1:0] {IDLE, LOADED, SHIFT};
  - default DATA_W;
  - the localparam for the frame length: DATA_W, or DATA_W+1 with parity.
- Sub-module spi_bit_counter: load/clear/increment counter with a terminal-count flag, parameterized by width and terminal value. It is reusable by the SIPO side.
- Shift register and FSM stay in spi_slave_piso.

Test Plan:
- Reset: hold rst=1 for 3 cycles with tx_valid=1 -> MISO=0, tx_ready=1, busy=0, tx_done=0, and no word accepted.
- Basic shift: accept 8'hA5 with SS_n=1 for 5 cycles, then SS_n=0 -> MISO over 8 cycles = 1,0,1,0,0,1,0,1; tx_done high exactly in cycle 9; busy low from then on.
- Hold: accept 8'h3C with SS_n high for 20 cycles -> MISO stays 0, busy=1, tx_ready=0. Then lower SS_n -> MISO = 0,0,1,1,1,1,0,0.
- Abort: send 8'hFF and raise SS_n after 3 bits -> MISO returns to 0 next cycle, no tx_done, tx_ready=1. A following 8'h81 transmits as 1,0,0,0,0,0,0,1.
- Back-to-back: with SS_n held low, offer 8'h0F during the tx_done cycle of 8'hF0 -> accepted; after one LOADED cycle, MISO shows 0,0,0,0,1,1,1,1.
- Parity (SPI_TX_PARITY_EN defined): 8'hA5 -> 9th bit = 1, tx_done in cycle 10. 8'h07 -> 9th bit = 0.

Source files
------------

// File: rtl/spi_tx_pkg.sv
// Shared types and sizing for the SPI slave transmit path.
// Optional macro SPI_TX_PARITY_EN appends an odd-parity bit to every frame.
package spi_tx_pkg;

    typedef enum logic [1:0] {IDLE, LOADED, SHIFT} state_e;

    localparam int DEF_DATA_W = 8;

    // Number of bits presented on MISO per accepted word.
    function automatic int frame_len(input int data_w);
`ifdef SPI_TX_PARITY_EN
        return data_w + 1;
`else
        return data_w;
`endif
    endfunction

    localparam int DEF_FRAME_W = frame_len(DEF_DATA_W);

endpackage

// File: rtl/spi_bit_counter.sv
// Bit counter with clear, load and increment (priority in that order)
// and a terminal-count flag; shared by the SPI shifters.
module spi_bit_counter #(
    parameter int CNT_W = 4,
    parameter int TERM  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             inc,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (load)
            cnt_d = load_val;
        else if (inc)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign tc = (cnt_q == CNT_W'(TERM));

endmodule

// File: rtl/spi_slave_piso.sv
// SPI slave transmit shifter: accepts a word by valid/ready, shifts it out
// MSB-first on MISO while SS_n is low. Optional macro: SPI_TX_PARITY_EN.
module spi_slave_piso
    import spi_tx_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = $clog2(DATA_W + 2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SS_n,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              MISO,
    output logic              busy,
    output logic              tx_done
);

    localparam int FRAME_W = frame_len(DATA_W);

    state_e               state_q, state_d;
    logic [FRAME_W-1:0]   shreg_q, shreg_d;
    logic                 miso_q, miso_d;
    logic                 done_q, done_d;
    logic                 cnt_tc;

    logic                 accept, start, shift_more, finish, abort_xfer;

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (tx_valid) state_d = LOADED;
            LOADED:  if (!SS_n) state_d = SHIFT;
            SHIFT:   if (SS_n || cnt_tc) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State-derived outputs and event decodes
    always_comb begin
        tx_ready   = (state_q == IDLE);
        busy       = (state_q != IDLE);
        accept     = (state_q == IDLE) && tx_valid;
        start      = (state_q == LOADED) && !SS_n;
        shift_more = (state_q == SHIFT) && !SS_n && !cnt_tc;
        finish     = (state_q == SHIFT) && !SS_n && cnt_tc;
        abort_xfer = (state_q == SHIFT) && SS_n;
    end

    // Datapath: MISO only ever carries a shifted bit, otherwise it idles low.
    always_comb begin
        shreg_d = shreg_q;
        if (accept) begin
`ifdef SPI_TX_PARITY_EN
            shreg_d = {tx_data, ~^tx_data};
`else
            shreg_d = tx_data;
`endif
        end else if (start || shift_more) begin
            shreg_d = shreg_q << 1;
        end
        miso_d = (start || shift_more) ? shreg_q[FRAME_W-1] : 1'b0;
        done_d = finish;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            miso_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            miso_q  <= miso_d;
            done_q  <= done_d;
        end
    end

    // Counter reaches FRAME_W once the last bit has been on MISO a full cycle.
    spi_bit_counter #(
        .CNT_W (CNT_W),
        .TERM  (FRAME_W)
    ) u_bit_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (finish || abort_xfer),
        .load     (start),
        .load_val (CNT_W'(1)),
        .inc      (shift_more),
        .tc       (cnt_tc)
    );

    assign MISO    = miso_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_spi_slave_piso.sv
// Self-checking bench for spi_slave_piso: directed cases plus random frames
// checked against a word-to-bitstream reference model.
module tb_spi_slave_piso;

    localparam int DATA_W = 8;
`ifdef SPI_TX_PARITY_EN
    localparam int FRAME = DATA_W + 1;
`else
    localparam int FRAME = DATA_W;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              SS_n;
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;
    logic              MISO;
    logic              busy;
    logic              tx_done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spi_slave_piso #(.DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .SS_n     (SS_n),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .MISO     (MISO),
        .busy     (busy),
        .tx_done  (tx_done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: bit i of the frame for word w (MSB first, then parity if enabled).
    function automatic logic exp_bit(input logic [DATA_W-1:0] w, input int i);
        int ones;
        if (i < DATA_W)
            return logic'((w >> (DATA_W - 1 - i)) & 1);
        ones = 0;
        for (int k = 0; k < DATA_W; k++)
            ones += int'(w[k]);
        return logic'((ones % 2) == 0);
    endfunction

    task automatic check_idle(input string tag);
        check_eq({tag, "_miso"},  MISO, 0);
        check_eq({tag, "_ready"}, tx_ready, 1);
        check_eq({tag, "_busy"},  busy, 0);
        check_eq({tag, "_done"},  tx_done, 0);
    endtask

    // One frame: optional handshake + hold, then shifting with optional abort
    // after abort_at bits (0 = none), optionally chaining next_w in the done cycle.
    task automatic run_frame(input logic [DATA_W-1:0] w, input int hold, input int abort_at,
                             input bit chained, input bit chain_next,
                             input logic [DATA_W-1:0] next_w);
        int n;
        int got_bits;
        got_bits = 0;
        if (!chained) begin
            n = 0;
            while (!tx_ready && n < 20) begin
                step();
                n++;
            end
            check_eq("ready_wait", tx_ready, 1);
            SS_n = 1'b1; tx_valid = 1'b1; tx_data = w;
            step();
            tx_data = DATA_W'($urandom);
            check_eq("acc_busy", busy, 1);
            check_eq("acc_ready", tx_ready, 0);
            check_eq("acc_miso", MISO, 0);
            for (int h = 0; h < hold; h++) begin
                tx_valid = 1'(h % 2);
                tx_data  = DATA_W'($urandom);
                step();
                check_eq("hold_miso", MISO, 0);
                check_eq("hold_busy", busy, 1);
                check_eq("hold_ready", tx_ready, 0);
            end
            tx_valid = 1'b0;
        end
        SS_n = 1'b0;
        step();
        for (int i = 0; i < FRAME; i++) begin
            check_eq("bit", MISO, exp_bit(w, i));
            check_eq("bit_done", tx_done, 0);
            got_bits = (got_bits << 1) | int'(MISO);
            if (abort_at == i + 1) begin
                SS_n = 1'b1;
                step();
                check_idle("abort");
                $display("frame word=%02h abort after %0d bits", w, abort_at);
                return;
            end
            step();
        end
        check_eq("done_pulse", tx_done, 1);
        check_eq("done_miso", MISO, 0);
        check_eq("done_ready", tx_ready, 1);
        check_eq("done_busy", busy, 0);
        $display("frame word=%02h bits=%0h hold=%0d chained=%0d", w, got_bits, hold, chained);
        if (chain_next) begin
            tx_valid = 1'b1; tx_data = next_w;
            step();
            tx_valid = 1'b0; tx_data = DATA_W'($urandom);
            check_eq("b2b_busy", busy, 1);
            check_eq("b2b_ready", tx_ready, 0);
            check_eq("b2b_done", tx_done, 0);
            check_eq("b2b_miso", MISO, 0);
        end else begin
            SS_n = 1'b1;
            step();
            check_idle("post");
        end
    endtask

    initial begin
        logic [DATA_W-1:0] w, nw;
        bit chain;
        int ab;

        rst = 1'b1; SS_n = 1'b0; tx_valid = 1'b1; tx_data = 8'hA5;
        for (int c = 0; c < 3; c++) begin
            step();
            check_idle("reset");
        end
        rst = 1'b0; tx_valid = 1'b0; SS_n = 1'b1;
        step();
        check_idle("post_reset");

        run_frame(8'hA5, 5, 0, 0, 0, 8'h00);
        run_frame(8'h3C, 20, 0, 0, 0, 8'h00);
        run_frame(8'hFF, 2, 3, 0, 0, 8'h00);
        run_frame(8'h81, 1, 0, 0, 0, 8'h00);
        run_frame(8'hF0, 1, 0, 0, 1, 8'h0F);
        run_frame(8'h0F, 0, 0, 1, 0, 8'h00);
        run_frame(8'h07, 0, 0, 0, 0, 8'h00);
        run_frame(8'hC3, 0, FRAME, 0, 0, 8'h00);

        // Reset in the middle of shifting: immediate abort, no tx_done.
        SS_n = 1'b1; tx_valid = 1'b1; tx_data = 8'h5A;
        step();
        tx_valid = 1'b0; SS_n = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        check_idle("midrst");
        rst = 1'b0; SS_n = 1'b1;
        step();
        check_idle("midrst_after");
        $display("mid-transfer reset checked");

        chain = 1'b0;
        w = DATA_W'($urandom);
        for (int t = 0; t < 30; t++) begin
            nw = DATA_W'($urandom);
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, FRAME)) : 0;
            run_frame(w, int'($urandom_range(0, 4)), ab, chain,
                      (ab == 0) && ($urandom_range(0, 2) == 0), nw);
            chain = (ab == 0) && busy;
            w = chain ? nw : DATA_W'($urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
